multiplier_seq: RTL and testbench

Sequential, handshaked multi-limb unsigned multiplier. It is the area-reduced successor to the fully combinational limb-array multiplier: it uses one row of NUM_ELEMENTS limb multipliers per cycle instead of a full NUM_ELEMENTS² array. Operands use redundant limbs (BIT_LEN bits each, limb weight 2^WORD_LEN). The result is fully carry-normalised, with one WORD_LEN-bit word per limb. It sits between operand staging and the modular-reduction stage of the big-integer datapath.

---
 rtl/multiplier_seq.sv | 177 +++++++++++++++++
 tb/tb_multiplier_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// multiplier_seq: sequential handshaked multi-limb unsigned multiplier.
// One row of NUM_ELEMENTS limb products is accumulated per cycle, then the
// 2N column sums are carry-normalised one column per cycle.
// Optional feature: define MULTIPLIER_SEQ_B2B_EN to accept a new operand pair
// on the same edge as the output handshake.
module multiplier_seq #(
  parameter int unsigned NUM_ELEMENTS = 17,
  parameter int unsigned BIT_LEN      = 17,
  parameter int unsigned WORD_LEN     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] A [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0] B [NUM_ELEMENTS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] M [2*NUM_ELEMENTS],
  output logic               busy
);

  localparam int unsigned N  = NUM_ELEMENTS;
  localparam int unsigned NC = 2 * NUM_ELEMENTS;
  localparam int unsigned PW = 2 * BIT_LEN;
  localparam int unsigned AW = PW + $clog2(NUM_ELEMENTS);
  localparam int unsigned TW = AW + 1;
  localparam int unsigned CW = TW - WORD_LEN;
  localparam int unsigned RW = $clog2(NUM_ELEMENTS);
  localparam int unsigned IW = $clog2(2 * NUM_ELEMENTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BIT_LEN-1:0] a_q   [N];
  logic [BIT_LEN-1:0] a_d   [N];
  logic [BIT_LEN-1:0] b_q   [N];
  logic [BIT_LEN-1:0] b_d   [N];
  logic [AW-1:0]      acc_q [NC];
  logic [AW-1:0]      acc_d [NC];
  logic [BIT_LEN-1:0] m_q   [NC];
  logic [BIT_LEN-1:0] m_d   [NC];
  logic [RW-1:0]      row_q, row_d;
  logic [IW-1:0]      col_q, col_d;
  logic [CW-1:0]      carry_q, carry_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               load_c;
  logic [BIT_LEN-1:0] a_sel_c;
  logic [PW-1:0]      prod_c [N];
  logic [TW-1:0]      t_c;
  logic [IW-1:0]      idx_c;

  // Operand capture: from IDLE, or (back-to-back build) on the output handshake.
`ifdef MULTIPLIER_SEQ_B2B_EN
  assign load_c   = in_valid && ((state_q == IDLE && in_ready_q) ||
                                 (state_q == DONE && out_ready));
  assign in_ready = in_ready_q || (state_q == DONE && out_ready);
`else
  assign load_c   = in_valid && (state_q == IDLE) && in_ready_q;
  assign in_ready = in_ready_q;
`endif

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign M         = m_q;

  // One row of limb products: A_reg[row] times every B_reg limb.
  always_comb begin
    a_sel_c = a_q[row_q];
    for (int j = 0; j < int'(N); j++) begin
      prod_c[j] = PW'(a_sel_c) * PW'(b_q[j]);
    end
  end

  // Column sum plus incoming carry for the normalisation pass.
  always_comb begin
    t_c = TW'(acc_q[col_q]) + TW'(carry_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    carry_d = carry_q;
    idx_c   = '0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      MUL: begin
        for (int j = 0; j < int'(N); j++) begin
          idx_c        = IW'(row_q) + IW'(j);
          acc_d[idx_c] = acc_q[idx_c] + AW'(prod_c[j]);
        end
        row_d = row_q + RW'(1);
        if (row_q == RW'(N - 1)) begin
          row_d   = '0;
          col_d   = '0;
          carry_d = '0;
          state_d = CARRY;
        end
      end
      CARRY: begin
        carry_d = CW'(t_c >> WORD_LEN);
        col_d   = col_q + IW'(1);
        if (col_q == IW'(NC - 1)) begin
          // Top limb keeps BIT_LEN bits; anything above is dropped.
          m_d[col_q] = t_c[BIT_LEN-1:0];
          col_d      = '0;
          state_d    = DONE;
        end else begin
          m_d[col_q] = BIT_LEN'(t_c[WORD_LEN-1:0]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_c) begin
      a_d     = A;
      b_d     = B;
      acc_d   = '{default: '0};
      row_d   = '0;
      state_d = MUL;
    end
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      acc_q       <= '{default: '0};
      m_q         <= '{default: '0};
      row_q       <= '0;
      col_q       <= '0;
      carry_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      row_q       <= row_d;
      col_q       <= col_d;
      carry_q     <= carry_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: directed N=2 vectors and corner
// sequences, then random big-integer regressions at N=2 and N=17.
module tb_multiplier_seq;

`ifdef MULTIPLIER_SEQ_B2B_EN
  localparam int  B2B_GAP    = 6;
  localparam bit  B2B_READY  = 1'b1;
`else
  localparam int  B2B_GAP    = 7;
  localparam bit  B2B_READY  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N = 2 instance
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [16:0] a2 [2];
  logic [16:0] b2 [2];
  logic [16:0] m2 [4];

  // N = 17 instance
  logic        in_valid17, in_ready17, out_valid17, out_ready17, busy17;
  logic [16:0] a17 [17];
  logic [16:0] b17 [17];
  logic [16:0] m17 [34];
  logic [16:0] exp17 [34];

  int tests = 0;
  int fails = 0;

  multiplier_seq #(.NUM_ELEMENTS(2), .BIT_LEN(17), .WORD_LEN(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .A(a2), .B(b2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .M(m2), .busy(busy2)
  );

  multiplier_seq u_dut17 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid17), .in_ready(in_ready17),
    .A(a17), .B(b17),
    .out_valid(out_valid17), .out_ready(out_ready17),
    .M(m17), .busy(busy17)
  );

  typedef struct {
    logic [16:0] a0, a1, b0, b1;
    logic [67:0] m;   // {M[3], M[2], M[1], M[0]}
  } vec_t;

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [67:0] pack2();
    return {m2[3], m2[2], m2[1], m2[0]};
  endfunction

  // Reference: evaluate operands as integers, multiply, slice into limbs.
  function automatic logic [67:0] model2(input logic [16:0] a0, a1, b0, b1);
    logic [79:0] va, vb, p;
    va = 80'(a0) + (80'(a1) << 16);
    vb = 80'(b0) + (80'(b1) << 16);
    p  = va * vb;
    return {p[48 +: 17], 1'b0, p[32 +: 16], 1'b0, p[16 +: 16], 1'b0, p[0 +: 16]};
  endfunction

  // One N=2 transaction; out_ready held low for 'stall' cycles after out_valid.
  task automatic op2(input logic [16:0] a0, a1, b0, b1, input int stall,
                     output logic [67:0] res, output int lat, output int unstable);
    int n;
    unstable = 0;
    @(negedge clk);
    n = 0;
    while (!in_ready2 && n < 50) begin @(negedge clk); n++; end
    a2[0] = a0; a2[1] = a1; b2[0] = b0; b2[1] = b1;
    in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(negedge clk);
    in_valid2 = 1'b0;
    a2[0] = 17'($urandom); a2[1] = 17'($urandom);
    b2[0] = 17'($urandom); b2[1] = 17'($urandom);
    lat = 0;
    while (!out_valid2 && lat < 100) begin @(negedge clk); lat++; end
    res = pack2();
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid2 || pack2() != res) unstable++;
    end
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    if (out_valid2) unstable++;
  endtask

  // One N=17 transaction on operands already placed in a17/b17.
  task automatic op17(input int stall, output int bad, output int lat, output int unstable);
    int n;
    logic [16:0] snap [34];
    bad = 0; unstable = 0;
    @(negedge clk);
    n = 0;
    while (!in_ready17 && n < 50) begin @(negedge clk); n++; end
    in_valid17 = 1'b1; out_ready17 = 1'b0;
    @(negedge clk);
    in_valid17 = 1'b0;
    for (int k = 0; k < 17; k++) begin a17[k] = 17'($urandom); b17[k] = 17'($urandom); end
    lat = 0;
    while (!out_valid17 && lat < 200) begin @(negedge clk); lat++; end
    for (int k = 0; k < 34; k++) begin
      snap[k] = m17[k];
      if (m17[k] !== exp17[k]) bad++;
    end
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid17) unstable++;
      for (int k = 0; k < 34; k++) if (m17[k] !== snap[k]) unstable++;
    end
    out_ready17 = 1'b1;
    @(negedge clk);
    out_ready17 = 1'b0;
    if (out_valid17) unstable++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    logic [67:0] res, expv;
    int          lat, unst, bad, n, e;
    bit          acc;
    logic [575:0] va, vb, p;

    vecs[0] = '{17'hFFFF,  17'hFFFF,  17'hFFFF,  17'hFFFF,  {17'hFFFF, 17'hFFFE, 17'h0, 17'h1}};
    vecs[1] = '{17'h10000, 17'h0,     17'h10000, 17'h0,     {17'h0, 17'h1, 17'h0, 17'h0}};
    vecs[2] = '{17'd3,     17'd0,     17'd5,     17'd0,     {17'h0, 17'h0, 17'h0, 17'd15}};
    vecs[3] = '{17'h0,     17'h1,     17'h0,     17'h1,     {17'h0, 17'h1, 17'h0, 17'h0}};
    vecs[4] = '{17'hFFFF,  17'h0,     17'h1FFFF, 17'h0,     {17'h0, 17'h1, 17'hFFFD, 17'h1}};
    vecs[5] = '{17'h0,     17'h0,     17'h1FFFF, 17'h1FFFF, {17'h0, 17'h0, 17'h0, 17'h0}};
    vecs[6] = '{17'h0,     17'h1FFFF, 17'h0,     17'h1FFFF, {17'h1FFFC, 17'h1, 17'h0, 17'h0}};

    rst_n = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_valid17 = 1'b0; out_ready17 = 1'b0;
    for (int k = 0; k < 2; k++) begin a2[k] = '0; b2[k] = '0; end
    for (int k = 0; k < 17; k++) begin a17[k] = '0; b17[k] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready2 == 1'b0 && in_ready17 == 1'b0,
          $sformatf("got %0b/%0b want 0/0", in_ready2, in_ready17));
    check("reset_out_valid_busy", {out_valid2, busy2, out_valid17, busy17} == 4'b0,
          $sformatf("got %b want 0000", {out_valid2, busy2, out_valid17, busy17}));
    check("reset_M", pack2() == 68'h0, $sformatf("got %h want 0", pack2()));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready2 == 1'b1 && busy2 == 1'b0,
          $sformatf("in_ready %0b busy %0b want 1/0", in_ready2, busy2));

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      op2(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, i % 3, res, lat, unst);
      check($sformatf("vec%0d_M", i), res == vecs[i].m,
            $sformatf("got %h want %h", res, vecs[i].m));
      check($sformatf("vec%0d_latency", i), lat == 6 && unst == 0,
            $sformatf("latency %0d unstable %0d want 6/0", lat, unst));
    end

    // Backpressure with in_valid held high throughout
    @(negedge clk);
    a2[0] = 17'hFFFF; a2[1] = 17'hFFFF; b2[0] = 17'hFFFF; b2[1] = 17'hFFFF;
    in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(negedge clk);
    a2[0] = 17'h1234; b2[1] = 17'h1ABCD;
    n = 0;
    while (!out_valid2 && n < 100) begin @(negedge clk); n++; end
    check("bp_result", pack2() == vecs[0].m && n == 6,
          $sformatf("M %h latency %0d want %h/6", pack2(), n, vecs[0].m));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pack2() != vecs[0].m || in_ready2 || !out_valid2) bad++;
    end
    check("bp_stall_hold", bad == 0, $sformatf("%0d bad stall cycles want 0", bad));
    out_ready2 = 1'b1; in_valid2 = 1'b0;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("bp_release", in_ready2 == 1'b1 && out_valid2 == 1'b0 && busy2 == 1'b0,
          $sformatf("in_ready %0b out_valid %0b busy %0b want 1/0/0", in_ready2, out_valid2, busy2));

    // Reset in the middle of the CARRY phase
    @(negedge clk);
    a2[0] = 17'hFFFF; a2[1] = 17'hFFFF; b2[0] = 17'hFFFF; b2[1] = 17'hFFFF;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_during_op", busy2 == 1'b1 && out_valid2 == 1'b0,
          $sformatf("busy %0b out_valid %0b want 1/0", busy2, out_valid2));
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {out_valid2, busy2, in_ready2} == 3'b0 && pack2() == 68'h0,
          $sformatf("ov/busy/rdy %b M %h want 000/0", {out_valid2, busy2, in_ready2}, pack2()));
    @(negedge clk);
    rst_n = 1'b1;
    op2(17'd3, 17'd0, 17'd5, 17'd0, 0, res, lat, unst);
    check("post_reset_op", res == 68'd15 && lat == 6,
          $sformatf("M %h latency %0d want f/6", res, lat));

    // Back-to-back: second pair waiting while the first completes
    @(negedge clk);
    a2[0] = 17'd3; a2[1] = 17'd0; b2[0] = 17'd5; b2[1] = 17'd0;
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    @(negedge clk);
    a2[0] = 17'd7; b2[0] = 17'd9;
    n = 0;
    while (!out_valid2 && n < 100) begin @(negedge clk); n++; end
    check("b2b_first_M", pack2() == 68'd15, $sformatf("got %h want f", pack2()));
    check("b2b_in_ready_done", in_ready2 == B2B_READY,
          $sformatf("got %0b want %0b", in_ready2, B2B_READY));
    acc = in_ready2 && in_valid2;
    e = -1;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (acc) in_valid2 = 1'b0;
      acc = in_ready2 && in_valid2;
    end while (!out_valid2 && e < 100);
    check("b2b_gap", e == B2B_GAP, $sformatf("got %0d edges want %0d", e, B2B_GAP));
    check("b2b_second_M", pack2() == 68'd63, $sformatf("got %h want 3f", pack2()));
    @(negedge clk);
    out_ready2 = 1'b0; in_valid2 = 1'b0;

    // Random N=2 regression, fully redundant 17-bit limbs
    for (int i = 0; i < 200; i++) begin
      logic [16:0] r0, r1, r2, r3;
      r0 = 17'($urandom); r1 = 17'($urandom); r2 = 17'($urandom); r3 = 17'($urandom);
      expv = model2(r0, r1, r2, r3);
      op2(r0, r1, r2, r3, int'($urandom_range(0, 2)), res, lat, unst);
      check($sformatf("rand2_%0d", i), res == expv && lat == 6 && unst == 0,
            $sformatf("M %h lat %0d unstable %0d want %h/6/0", res, lat, unst, expv));
    end

    // Random N=17 regression, operands below 2^272
    for (int i = 0; i < 1000; i++) begin
      bit redundant;
      redundant = 1'($urandom_range(0, 1));
      va = '0; vb = '0;
      for (int k = 0; k < 17; k++) begin
        if (!redundant) begin
          a17[k] = 17'($urandom_range(0, 16'hFFFF));
          b17[k] = 17'($urandom_range(0, 16'hFFFF));
        end else if (k < 16) begin
          a17[k] = 17'($urandom);
          b17[k] = 17'($urandom);
        end else begin
          a17[k] = 17'($urandom_range(0, 15'h7FFF));
          b17[k] = 17'($urandom_range(0, 15'h7FFF));
        end
        va = va + (576'(a17[k]) << (16 * k));
        vb = vb + (576'(b17[k]) << (16 * k));
      end
      p = va * vb;
      for (int k = 0; k < 34; k++) begin
        exp17[k] = (k < 33) ? 17'(p[16*k +: 16]) : p[528 +: 17];
      end
      op17(int'($urandom_range(0, 2)), bad, lat, unst);
      check($sformatf("rand17_%0d", i), bad == 0 && lat == 51 && unst == 0,
            $sformatf("bad limbs %0d lat %0d unstable %0d want 0/51/0", bad, lat, unst));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
